// File: rtl/axi4_master.sv
// AXI4 manager: one client command becomes one INCR burst on AW/W/B or AR/R, one completion per command.
// Latency: AxVALID the cycle after accept; done one cycle after the last B/R handshake; cmd_ready one cycle later.
// Backpressure: client write/read streams pass straight through to W/R, so stalls on either side hold the FSM.
module axi4_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    rd_last,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic                    done_proto_err,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic                    BREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [7:0]            beat_cnt_q;
  logic [1:0]            resp_acc_q;
  logic                  proto_q;
  logic                  awvalid_q, arvalid_q, bready_q, cmd_ready_q;
  logic                  done_q, done_perr_q;
  logic [1:0]            done_resp_q;

  logic       cmd_acc, size_bad, last_beat, w_hs, r_hs, rlast_bad;
  logic [1:0] r_resp_max;

  assign cmd_acc    = cmd_valid && cmd_ready_q && (state_q == S_IDLE);
  assign size_bad   = cmd_size > MAX_SIZE;
  assign last_beat  = beat_cnt_q == len_q;
  assign w_hs       = (state_q == S_W) && wr_valid && WREADY;
  assign r_hs       = (state_q == S_R) && RVALID && rd_ready;
  assign rlast_bad  = RLAST != last_beat;
  // Response codes order by severity numerically: OKAY < SLVERR < DECERR.
  assign r_resp_max = (RRESP > resp_acc_q) ? RRESP : resp_acc_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_acc) state_d = size_bad ? S_ERR : (cmd_write ? S_AW : S_AR);
      S_AW:    if (awvalid_q && AWREADY) state_d = S_W;
      S_W:     if (w_hs && last_beat) state_d = S_B;
      S_B:     if (BVALID) state_d = S_IDLE;
      S_AR:    if (arvalid_q && ARREADY) state_d = S_R;
      S_R:     if (r_hs && last_beat) state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    WVALID   = 1'b0;
    wr_ready = 1'b0;
    WLAST    = 1'b0;
    RREADY   = 1'b0;
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    rd_data  = '0;
    if (state_q == S_W) begin
      WVALID   = wr_valid;
      wr_ready = WREADY;
      WLAST    = last_beat;
    end
    if (state_q == S_R) begin
      RREADY   = rd_ready;
      rd_valid = RVALID;
      rd_last  = RLAST;
      rd_data  = RDATA;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      beat_cnt_q  <= '0;
      resp_acc_q  <= '0;
      proto_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      done_resp_q <= '0;
      done_perr_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Hold off the next command until the completion pulse has been seen.
      if (done_q) cmd_ready_q <= 1'b1;
      case (state_q)
        S_IDLE: if (cmd_acc) begin
          addr_q      <= cmd_addr;
          len_q       <= cmd_len;
          size_q      <= cmd_size;
          beat_cnt_q  <= '0;
          resp_acc_q  <= '0;
          proto_q     <= 1'b0;
          cmd_ready_q <= 1'b0;
          awvalid_q   <= cmd_write && !size_bad;
          arvalid_q   <= !cmd_write && !size_bad;
        end
        S_AW: if (AWREADY) awvalid_q <= 1'b0;
        S_AR: if (ARREADY) arvalid_q <= 1'b0;
        S_W: if (w_hs) begin
          beat_cnt_q <= beat_cnt_q + 8'd1;
          if (last_beat) bready_q <= 1'b1;
        end
        S_B: if (BVALID) begin
          bready_q    <= 1'b0;
          done_q      <= 1'b1;
          done_resp_q <= BRESP;
          done_perr_q <= 1'b0;
        end
        S_R: if (r_hs) begin
          beat_cnt_q <= beat_cnt_q + 8'd1;
          resp_acc_q <= r_resp_max;
          if (rlast_bad) proto_q <= 1'b1;
          // The beat count, not RLAST, decides where the burst ends.
          if (last_beat) begin
            done_q      <= 1'b1;
            done_resp_q <= r_resp_max;
            done_perr_q <= proto_q || rlast_bad;
          end
        end
        S_ERR: begin
          done_q      <= 1'b1;
          done_resp_q <= 2'b10;
          done_perr_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign done           = done_q;
  assign done_resp      = done_resp_q;
  assign done_proto_err = done_perr_q;
  assign AWADDR         = addr_q;
  assign AWLEN          = len_q;
  assign AWSIZE         = size_q;
  assign AWBURST        = 2'b01;
  assign AWVALID        = awvalid_q;
  assign ARADDR         = addr_q;
  assign ARLEN          = len_q;
  assign ARSIZE         = size_q;
  assign ARBURST        = 2'b01;
  assign ARVALID        = arvalid_q;
  assign BREADY         = bready_q;
  assign WDATA          = wr_data;
  assign WSTRB          = '1;

endmodule

// File: doc/axi4_master.md
Name: axi4_master

Overview:
AXI4 initiator (manager) that converts single-transaction commands from a local client into AXI4 INCR bursts on the full AW/W/B/AR/R channels. It is the counterpart of the team's axi4 memory-mapped responder and drives it directly in the system and in the testbench environment. Write data is streamed in from the client and read data is streamed out to it. One transaction is in flight at a time, and a completion record is returned per command.

Parameters:
DATA_WIDTH, 32, data bus width in bits (power of 2, >= 8)
ADDR_WIDTH, 16, byte address width

Ports:
ACLK  in  1  clock; all logic on the rising edge
ARESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  client command valid
cmd_ready  out  1  master idle; command accepted on cmd_valid & cmd_ready
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  start byte address
cmd_len  in  8  beats minus 1 (AxLEN)
cmd_size  in  3  log2 bytes per beat (AxSIZE)
wr_data  in  DATA_WIDTH  client write beat
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat taken
rd_data  out  DATA_WIDTH  read beat to client
rd_valid  out  1  read beat valid
rd_ready  in  1  client accepts read beat
rd_last  out  1  final read beat
done  out  1  one-cycle completion pulse
done_resp  out  2  worst response of the transaction (OKAY=00 < SLVERR=10 < DECERR=11)
done_proto_err  out  1  RLAST/beat-count mismatch seen
AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ADDR_WIDTH/8/3/2/1  write address channel
AWREADY  in  1
WDATA/WSTRB/WLAST/WVALID  out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
WREADY  in  1
BREADY  out  1; BRESP in 2; BVALID in 1
ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  as AW*; ARREADY in 1
RDATA in DATA_WIDTH; RRESP in 2; RLAST in 1; RVALID in 1; RREADY out 1

Behaviour:
- Reset values: cmd_ready=1; AWVALID, WVALID, BREADY, ARVALID, RREADY, done, done_proto_err = 0; done_resp = 00; all address, len and size registers = 0.
- AxBURST is fixed at 2'b01 (INCR). WSTRB is all ones.
- FSM states: IDLE, AW, W, B, AR, R, ERR.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr/len/size/write, clear beat_cnt (8 bit), clear resp_acc and proto flag, and drop cmd_ready.
  - If cmd_size > log2(DATA_WIDTH/8), go to ERR. Otherwise go to AW (write) or AR (read).
- ERR: no bus activity. The next cycle pulses done with done_resp=10, then returns to IDLE.
- AW/AR:
  - Registered AxVALID is high the cycle after command accept and stays high with stable payload until AxREADY is sampled high.
  - Then go to W or R respectively.
- W:
  - WVALID = wr_valid and wr_ready = WREADY (both gated by state==W). WDATA = wr_data.
  - WLAST = (beat_cnt == len). beat_cnt increments per W handshake.
  - The handshake with WLAST goes to B. W is never entered before the AW handshake completes.
- B: BREADY=1 (registered on entry). On BVALID, pulse done with done_resp=BRESP and go to IDLE.
- R:
  - RREADY = rd_ready; rd_valid = RVALID; rd_data = RDATA; rd_last = RLAST (gated by state==R).
  - Per handshake: resp_acc = max(resp_acc, RRESP), and beat_cnt increments.
  - If RLAST != (beat_cnt==len), set proto flag.
  - The handshake at beat_cnt==len pulses done with done_resp=max(resp_acc,RRESP) and done_proto_err=flag, then goes to IDLE. An early RLAST does not end the burst.
- done and done_* are valid only during the done cycle and hold their values otherwise. cmd_ready rises the cycle after done.
- Client stalls (wr_valid=0, rd_ready=0) hold the FSM indefinitely. There is no timeout.
- Asynchronous reset mid-transaction returns immediately to reset values. No completion is reported for the aborted transaction.
- Addresses are driven unmodified; 4KB crossing and range checks are the responder's job.

Test Plan:
- Single write: cmd addr=0x0010, len=0, size=2, wr_data=0xDEADBEEF -> one AW with AWLEN=0 and one W beat with WLAST=1; done pulse with done_resp=00.
- Write then read: 4-beat write at 0x0100 (size=2) with data 0x11..0x44, then a read of the same -> AW/AR len=3; WLAST only on beat 4; rd_data 0x11,0x22,0x33,0x44 with rd_last on the 4th; both done_resp=00.
- Out-of-range: read at 0x1000 with len=1 to the axi4 responder (depth 1024) -> 2 beats with RRESP=10; done_resp=10 and done_proto_err=0.
- Backpressure: rd_ready toggling 1010 and wr_valid gaps during 8-beat bursts -> no lost or duplicated beats; AxVALID held with stable payload until AxREADY.
- Illegal size: cmd_size=3 with DATA_WIDTH=32 -> no AWVALID/ARVALID ever; done two cycles after accept with done_resp=10.
- Protocol and reset: responder model asserts RLAST on beat 2 of a len=3 read -> 4 beats consumed and done_proto_err=1; ARESETn pulsed low mid-W burst -> all VALID/READY outputs 0 and cmd_ready=1 immediately.
